// File: rtl/alu_pkg.sv
// Shared opcode definitions for the four-bit ALU execute stage.
package alu_pkg;

   localparam int unsigned OPCODE_W = 3;

   typedef enum logic [OPCODE_W-1:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } alu_op_e;

endpackage

// File: rtl/alu_four_bit_core.sv
// Combinational ALU datapath: result and flags for one operation.
module alu_four_bit_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0]    A,
   input  logic [WIDTH-1:0]    B,
   input  logic [OPCODE_W-1:0] opcode,
   output logic [WIDTH-1:0]    next_result,
   output logic                next_cf,
   output logic                next_zf,
   output logic                next_pf
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   // Zero-extended operands: the extra MSB is the unsigned carry, or the borrow on subtract.
   assign sum  = {1'b0, A} + {1'b0, B};
   assign diff = {1'b0, A} - {1'b0, B};

   always_comb begin
      next_result = '0;
      next_cf     = 1'b0;
      unique case (alu_op_e'(opcode))
         OP_ADD: begin
            next_result = sum[WIDTH-1:0];
            next_cf     = sum[WIDTH];
         end
         OP_SUB: begin
            next_result = diff[WIDTH-1:0];
            next_cf     = diff[WIDTH];
         end
         OP_AND: next_result = A & B;
         OP_OR:  next_result = A | B;
         OP_XOR: next_result = A ^ B;
         OP_NOT: next_result = ~A;
         OP_SHL: begin
            next_result = {A[WIDTH-2:0], 1'b0};
            next_cf     = A[WIDTH-1];
         end
         OP_SHR: begin
            next_result = {1'b0, A[WIDTH-1:1]};
            next_cf     = A[0];
         end
         default: begin
            next_result = '0;
            next_cf     = 1'b0;
         end
      endcase
   end

   assign next_zf = (next_result == '0);
   assign next_pf = ~^next_result;

endmodule

// File: rtl/alu_four_bit.sv
// Registered ALU execute stage: one-cycle latency, result and flags share one edge.
module alu_four_bit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [WIDTH-1:0]    A,
   input  logic [WIDTH-1:0]    B,
   input  logic [OPCODE_W-1:0] opcode,
   output logic [WIDTH-1:0]    Result,
   output logic                ZF,
   output logic                CF,
   output logic                PF
);

   logic [WIDTH-1:0] next_result;
   logic             next_cf;
   logic             next_zf;
   logic             next_pf;

   alu_four_bit_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .A           (A),
      .B           (B),
      .opcode      (opcode),
      .next_result (next_result),
      .next_cf     (next_cf),
      .next_zf     (next_zf),
      .next_pf     (next_pf)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Result <= '0;
         ZF     <= 1'b0;
         CF     <= 1'b0;
         PF     <= 1'b0;
      end else begin
         Result <= next_result;
         ZF     <= next_zf;
         CF     <= next_cf;
         PF     <= next_pf;
      end
   end

endmodule

// File: tb/tb_alu_four_bit.sv
// Self-checking bench for alu_four_bit: directed table, exhaustive sweep, mid-stream reset.
module tb_alu_four_bit;

   logic       clk;
   logic       rst_n;
   logic [3:0] A;
   logic [3:0] B;
   logic [2:0] opcode;
   logic [3:0] Result;
   logic       ZF;
   logic       CF;
   logic       PF;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] res;
      logic       zf;
      logic       cf;
      logic       pf;
   } exp_t;

   typedef struct {
      logic       rstn;
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
      logic [3:0] res;
      logic       zf;
      logic       cf;
      logic       pf;
   } vec_t;

   exp_t sb[$];

   alu_four_bit #(
      .WIDTH(4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .A      (A),
      .B      (B),
      .opcode (opcode),
      .Result (Result),
      .ZF     (ZF),
      .CF     (CF),
      .PF     (PF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input int a, input int b, input int op, input bit rstn);
      exp_t e;
      int   r;
      int   c;
      int   ones;
      c = 0;
      case (op)
         0: begin r = (a + b) % 16; c = (a + b > 15) ? 1 : 0; end
         1: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = 15 - a;
         6: begin r = (a * 2) % 16; c = (a >= 8) ? 1 : 0; end
         default: begin r = a / 2; c = a % 2; end
      endcase
      ones = 0;
      for (int i = 0; i < 4; i++) ones += (r >> i) & 1;
      e.res = 4'(r);
      e.cf  = (c != 0);
      e.zf  = (r == 0);
      e.pf  = (ones % 2 == 0);
      if (!rstn) begin
         e.res = 4'h0;
         e.zf  = 1'b0;
         e.cf  = 1'b0;
         e.pf  = 1'b0;
      end
      return e;
   endfunction

   task automatic check_out(input string name);
      exp_t e;
      e = sb.pop_front();
      total++;
      if ({Result, ZF, CF, PF} !== {e.res, e.zf, e.cf, e.pf}) begin
         bad++;
         $display("FAIL %s: got R=%h ZF=%b CF=%b PF=%b, expected R=%h ZF=%b CF=%b PF=%b",
                  name, Result, ZF, CF, PF, e.res, e.zf, e.cf, e.pf);
      end
   endtask

   // Drive one cycle, enqueue its expected output, then check after the capturing edge.
   task automatic step(input logic rstn, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input exp_t e, input string name);
      @(negedge clk);
      rst_n  = rstn;
      A      = a;
      B      = b;
      opcode = op;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out(name);
   endtask

   vec_t vecs[$];

   function automatic vec_t mk(input logic rstn, input logic [3:0] a, input logic [3:0] b,
                               input logic [2:0] op, input logic [3:0] res,
                               input logic zf, input logic cf, input logic pf);
      vec_t v;
      v.rstn = rstn; v.a = a; v.b = b; v.op = op;
      v.res = res; v.zf = zf; v.cf = cf; v.pf = pf;
      return v;
   endfunction

   initial begin
      exp_t e;
      rst_n  = 1'b0;
      A      = 4'h0;
      B      = 4'h0;
      opcode = 3'b000;

      vecs.push_back(mk(1'b0, 4'h7, 4'h9, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 4'h7, 4'h9, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'h7, 4'h9, 3'b000, 4'h0, 1'b1, 1'b1, 1'b1));
      vecs.push_back(mk(1'b1, 4'h3, 4'h5, 3'b001, 4'hE, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 4'h5, 4'h5, 3'b001, 4'h0, 1'b1, 1'b0, 1'b1));
      vecs.push_back(mk(1'b1, 4'hF, 4'hA, 3'b010, 4'hA, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b1, 4'hF, 4'hA, 3'b011, 4'hF, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b1, 4'hF, 4'hA, 3'b100, 4'h5, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b1, 4'hF, 4'hA, 3'b101, 4'h0, 1'b1, 1'b0, 1'b1));
      vecs.push_back(mk(1'b1, 4'h9, 4'h0, 3'b110, 4'h2, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 4'h3, 4'h0, 3'b111, 4'h1, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 4'h8, 4'h8, 3'b000, 4'h0, 1'b1, 1'b1, 1'b1));
      vecs.push_back(mk(1'b1, 4'h0, 4'h1, 3'b001, 4'hF, 1'b0, 1'b1, 1'b1));
      vecs.push_back(mk(1'b1, 4'h6, 4'h3, 3'b000, 4'h9, 1'b0, 1'b0, 1'b1));

      foreach (vecs[i]) begin
         e.res = vecs[i].res;
         e.zf  = vecs[i].zf;
         e.cf  = vecs[i].cf;
         e.pf  = vecs[i].pf;
         step(vecs[i].rstn, vecs[i].a, vecs[i].b, vecs[i].op, e, $sformatf("vec%0d", i));
      end

      // Exhaustive sweep with a reset pulse in the middle of the SUB/AND region.
      for (int op = 0; op < 8; op++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               if (op == 2 && a == 5 && b == 3) begin
                  step(1'b0, 4'(a), 4'(b), 3'(op), model(a, b, op, 1'b0), "midreset");
                  step(1'b0, 4'hF, 4'hF, 3'b000, model(15, 15, 0, 1'b0), "midreset_hold");
               end
               step(1'b1, 4'(a), 4'(b), 3'(op), model(a, b, op, 1'b1),
                    $sformatf("sweep op=%0d a=%0d b=%0d", op, a, b));
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_four_bit.md
Name: alu_four_bit

Overview:
- 4-bit, 8-operation arithmetic/logic unit with registered result and status flags (zero, carry, parity).
- Used as a small datapath execute stage: operands and opcode are presented every cycle, and the result and flags appear one clock later.
- Operands are two's-complement signed; result bits are width-truncated; the carry flag is computed on unsigned interpretation.

Parameters:
- WIDTH, 4, operand/result width; the flag definitions below hold for any WIDTH ≥ 2, and verification targets 4.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- A  input  WIDTH  operand A, signed.
- B  input  WIDTH  operand B, signed.
- opcode  input  3  operation select (encodings below).
- Result  output  WIDTH  registered operation result.
- ZF  output  1  registered zero flag.
- CF  output  1  registered carry/borrow/shift-out flag.
- PF  output  1  registered even-parity flag.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: while rst_n=0 at a rising edge, Result=0, ZF=0, CF=0, PF=0. A reset asserted mid-stream discards the in-flight operation; the first valid output follows 1 cycle after rst_n returns high.
- Latency: exactly 1 cycle. Inputs sampled at edge N drive outputs after edge N.
- Throughput: a new operation every cycle. There is no handshake and no stall.
- Opcodes and CF rule:
  - 000 ADD: Result = A+B mod 2^WIDTH; CF = unsigned carry out of the MSB.
  - 001 SUB: Result = A−B mod 2^WIDTH; CF = borrow, i.e. 1 when unsigned A < unsigned B.
  - 010 AND: Result = A & B; CF = 0.
  - 011 OR: Result = A | B; CF = 0.
  - 100 XOR: Result = A ^ B; CF = 0.
  - 101 NOT: Result = ~A; B ignored; CF = 0.
  - 110 SHL: Result = A << 1, LSB filled with 0; CF = A[MSB].
  - 111 SHR: logical shift, Result = A >> 1, MSB filled with 0; CF = A[0].
- ZF = 1 iff the next Result is all zeros. This applies to every opcode, including ADD wrap-around to 0.
- PF = 1 iff the next Result has an even number of 1 bits; a zero Result gives PF=1.
- Signed operands do not change the result bits. No overflow flag is produced.
- All flags are derived from the same combinational result as Result and register on the same edge; there is no stale-flag skew.
- X/undefined opcode values are not required to be handled. Every 3-bit value is a defined operation.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams/enum: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR.
  - opcode width constant = 3.
- Sub-module alu_four_bit_core: purely combinational. It takes A, B and opcode and produces next_result, next_cf, next_zf and next_pf.
- The top level holds only the output registers and the reset logic.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with A=4'h7, B=4'h9, opcode=000 → Result=0, ZF=0, CF=0, PF=0. Release reset → 1 cycle later Result=0, CF=1, ZF=1, PF=1 (7+9 wraps).
- SUB borrow: A=4'h3, B=4'h5, op=001 → Result=4'hE, CF=1, ZF=0, PF=0. Then A=4'h5, B=4'h5 → Result=0, CF=0, ZF=1, PF=1.
- Logic: A=4'hF, B=4'hA, op=010 → 4'hA, CF=0, PF=1. Same inputs with op=011 → 4'hF, PF=1. With op=100 → 4'h5, PF=1. With op=101 → 4'h0, ZF=1.
- Shifts: A=4'h9, op=110 → Result=4'h2, CF=1, PF=0. A=4'h3, op=111 → Result=4'h1, CF=1, PF=0.
- Exhaustive sweep: all 8 opcodes × 16 A × 16 B, one per cycle. Compare each output against a reference model delayed by 1 cycle; 2048 vectors with zero mismatches.
- Mid-stream reset: assert rst_n=0 during the sweep → outputs 0 on the next edge. After release, the next output corresponds to the first input sampled with rst_n=1.
